// File: rtl/bfp16_pkg.sv
// rtl/bfp16_pkg.sv - shared BFP16 types, constants and divider FSM states
package bfp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bfp16_t;

  localparam int          BFP16_EXP_BIAS  = 127;
  localparam logic [15:0] BFP16_QNAN      = 16'h7FC0;
  localparam int          BFP16_DIV_ITERS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/bfp16_classify.sv
// rtl/bfp16_classify.sv - per-operand NaN / infinity / zero detection
// Subnormals are treated as zero.
module bfp16_classify
  import bfp16_pkg::*;
(
  input  logic [15:0] x_i,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_o
);

  bfp16_t v;
  assign v = x_i;

  assign is_nan_o  = (v.exp == 8'hFF) && (v.frac != 7'h0);
  assign is_inf_o  = (v.exp == 8'hFF) && (v.frac == 7'h0);
  assign is_zero_o = (v.exp == 8'h00);

endmodule

// File: rtl/bfp16_div.sv
// rtl/bfp16_div.sv - sequential BFP16 restoring divider, one quotient bit per cycle
// Define BFP16_DIV_RNE_EN for round-to-nearest-even; default build truncates.
module bfp16_div
  import bfp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] O,
  input  logic        out_ready,
  output logic        out_valid
);

  div_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [9:0]        q_q, q_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        mb_q, mb_d;
  logic signed [9:0] e_q, e_d;
  logic              sign_q, sign_d;
  logic [15:0]       o_q, o_d;
  logic              out_valid_q, out_valid_d;

  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  bfp16_classify u_cls_a (.x_i(A), .is_nan_o(a_nan), .is_inf_o(a_inf), .is_zero_o(a_zero));
  bfp16_classify u_cls_b (.x_i(B), .is_nan_o(b_nan), .is_inf_o(b_inf), .is_zero_o(b_zero));

  bfp16_t a_f, b_f;
  assign a_f = A;
  assign b_f = B;

  logic        res_sign;
  logic        spec_hit;
  logic [15:0] spec_val;
  logic [9:0]  e_load;

  assign res_sign = a_f.sign ^ b_f.sign;
  assign e_load   = {2'b00, a_f.exp} - {2'b00, b_f.exp} + 10'(BFP16_EXP_BIAS);

  always_comb begin
    spec_hit = 1'b1;
    spec_val = 16'h0000;
    if (a_nan)                                spec_val = {a_f.sign, 8'hFF, a_f.frac};
    else if (b_nan)                           spec_val = {b_f.sign, 8'hFF, b_f.frac};
    else if ((a_inf && b_inf) || (a_zero && b_zero)) spec_val = BFP16_QNAN;
    else if (a_inf || b_zero)                 spec_val = {res_sign, 8'hFF, 7'h00};
    else if (a_zero || b_inf)                 spec_val = {res_sign, 8'h00, 7'h00};
    else                                      spec_hit = 1'b0;
  end

  // Restoring step: remainder stays below 2*mb, so 9 bits suffice.
  logic       rem_ge;
  logic [8:0] rem_sub;
  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalisation: the leading 1 sits at q[9] or q[8] since both mantissas are in [1,2).
  logic [6:0]        frac_n;
  logic signed [9:0] e_n;
  logic              round_up;
  logic [7:0]        frac_r;
  logic signed [9:0] e_f;
  logic [15:0]       norm_val;

  always_comb begin
    frac_n = q_q[9] ? q_q[8:2] : q_q[7:1];
    e_n    = q_q[9] ? e_q : (e_q - 10'sd1);
  end

`ifdef BFP16_DIV_RNE_EN
  logic guard, sticky, lsb;
  always_comb begin
    guard    = q_q[9] ? q_q[1] : q_q[0];
    sticky   = q_q[9] ? (q_q[0] | (rem_q != 9'd0)) : (rem_q != 9'd0);
    lsb      = frac_n[0];
    round_up = guard && (sticky || lsb);
  end
`else
  assign round_up = 1'b0;
`endif

  // A carry out of the fraction means the mantissa wrapped to 1.0 of the next binade.
  always_comb begin
    frac_r = {1'b0, frac_n} + {7'h00, round_up};
    e_f    = e_n + $signed({9'd0, frac_r[7]});
    if (e_f >= 10'sd255)     norm_val = {sign_q, 8'hFF, 7'h00};
    else if (e_f <= 10'sd0)  norm_val = {sign_q, 15'h0000};
    else                     norm_val = {sign_q, e_f[7:0], frac_r[6:0]};
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign O         = o_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    rem_d       = rem_q;
    mb_d        = mb_q;
    e_d         = e_q;
    sign_d      = sign_q;
    o_d         = o_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (spec_hit) begin
            o_d     = spec_val;
            state_d = ST_DONE;
          end else begin
            mb_d    = {1'b1, b_f.frac};
            rem_d   = {2'b01, a_f.frac};
            q_d     = 10'd0;
            cnt_d   = 4'd0;
            e_d     = e_load;
            sign_d  = res_sign;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        q_d   = {q_q[8:0], rem_ge};
        rem_d = {rem_sub[7:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BFP16_DIV_ITERS - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        o_d     = norm_val;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // out_valid trails DONE entry by one edge; the handoff needs it high.
        if (out_valid_q && out_ready) state_d = ST_IDLE;
        else                          out_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      q_q         <= 10'd0;
      rem_q       <= 9'd0;
      mb_q        <= 8'd0;
      e_q         <= 10'sd0;
      sign_q      <= 1'b0;
      o_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      mb_q        <= mb_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bfp16_div.sv
// tb/tb_bfp16_div.sv - directed self-checking bench for bfp16_div
module tb_bfp16_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] O;

  int checks = 0;
  int errors = 0;

`ifdef BFP16_DIV_RNE_EN
  localparam logic [15:0] THIRD = 16'h3EAB;
`else
  localparam logic [15:0] THIRD = 16'h3EAA;
`endif

  bfp16_div dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .O(O), .out_ready(out_ready), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expo,
                    input int explat, input string tag);
    int lat;
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, explat);
    chk({tag, " O"}, O, expo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after handoff"}, out_valid, 1'b0);
    chk({tag, " in_ready after handoff"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset O", O, 16'h0000);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", in_ready, 1'b1);

    op(16'h3F80, 16'h4000, 16'h3F00, 12, "1/2");
    op(16'h4040, 16'h3FC0, 16'h4000, 12, "3/1.5");
    op(16'h3F80, 16'h4040, THIRD,    12, "1/3");

    op(16'h0000, 16'h0000, 16'h7FC0, 1, "0/0");
    op(16'hC000, 16'h0000, 16'hFF80, 1, "-2/0");
    op(16'h7F80, 16'h7F80, 16'h7FC0, 1, "inf/inf");
    op(16'h3F80, 16'h7F80, 16'h0000, 1, "1/inf");
    op(16'h7FC1, 16'h3F80, 16'h7FC1, 1, "nan/1");

    op(16'h7F00, 16'h0080, 16'h7F80, 12, "overflow");
    op(16'h0080, 16'h4000, 16'h0000, 12, "flush");
    op(16'h0001, 16'h3F80, 16'h0000, 1,  "subnormal");

    // Ignored in_valid during DIV, then backpressure in DONE.
    A = 16'h4040; B = 16'h3FC0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    A = 16'h7FC1; B = 16'h0000; in_valid = 1'b1;
    chk("busy in_ready", in_ready, 1'b0);
    repeat (2) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy latency", lat, 12);
    for (int i = 0; i < 5; i++) begin
      chk("stall O", O, 16'h4000);
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall handoff out_valid", out_valid, 1'b0);

    // Abort in the middle of DIV.
    A = 16'h3F80; B = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort in_ready", in_ready, 1'b1);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    chk("abort no result", seen, 0);
    op(16'h4000, 16'h4000, 16'h3F80, 12, "2/2 after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfp16_div.md
# bfp16_div

Sequential BFP16 divider (1 sign, 8 exponent, 7 fraction bits) computing O = A / B by restoring division, one quotient bit per cycle. It is the inverse-direction companion to the single-cycle BFP16 multiplier in the SA datapath and serves normalisation and softmax scaling. Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake.

## Interface
- No parameters. Iteration count and bias are fixed constants (see Structure).
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- A  input  16  dividend, BFP16
- B  input  16  divisor, BFP16
- in_valid  input  1  operands A/B valid
- in_ready  output  1  divider idle, can accept operands
- O  output  16  quotient, BFP16
- out_valid  output  1  O valid
- out_ready  input  1  consumer takes O

## Operation
- FSM states: IDLE, DIV, NORM, DONE. Reset state is IDLE.
- in_ready = (state == IDLE) && !rst. Accept occurs on an edge with in_valid && in_ready; A/B are captured at that edge.
- Classification at accept, in priority order:
  - A NaN: O = {A[15], 8'hFF, A[6:0]}.
  - B NaN: O = {B[15], 8'hFF, B[6:0]}.
  - inf/inf or 0/0: O = 16'h7FC0.
  - A inf or B zero: O = {sA^sB, 8'hFF, 7'h0}.
  - A zero or B inf: O = {sA^sB, 8'h00, 7'h0}.
- Subnormal inputs (exponent 0, fraction nonzero) are zero for every purpose.
- Any special case: next state is DONE with O loaded.
- Otherwise: next state is DIV.
  - Load ma = {1, A[6:0]}, mb = {1, B[6:0]}, rem = {1'b0, ma} (9 bits).
  - Load e = eA − eB + 127 as signed 10-bit, sign = sA^sB, iteration counter = 0.
- DIV step, each cycle, 10 cycles in total:
  - If rem ≥ mb: q bit = 1 and rem −= mb; else q bit = 0.
  - Then rem <<= 1 and shift q (10 bits) left by one, MSB first.
- NORM, one cycle:
  - If q[9]: mant = q[9:2], guard = q[8]... specifically guard = q[1], sticky = q[0] | (rem != 0).
  - Else: mant = q[8:1], guard = q[0], sticky = (rem != 0), e −= 1.
  - Rounding per Configuration. A mantissa carry out (0xFF → 0x100) sets mant = 0x80 and e += 1.
  - e ≥ 255: O = {sign, 8'hFF, 7'h0}.
  - e ≤ 0: O = {sign, 15'h0} (flush to zero).
  - Else: O = {sign, e[7:0], mant[6:0]}.
  - Next state is DONE.
- DONE: out_valid = 1 and O is held stable. When out_ready is 1, next state is IDLE. in_ready stays 0 until then.

## Timing
- Reset values: O = 16'h0000, out_valid = 0, state IDLE, counter 0, q 0, rem 0. in_ready reads 0 while rst is high and 1 on the first cycle after.
- Normal latency: out_valid rises 12 edges after the accept edge (10 DIV + 1 NORM + 1 entry to DONE).
- Special-case latency: out_valid rises 1 edge after the accept edge.
- Throughput: the next accept occurs at the earliest one cycle after the out_valid && out_ready handoff (one op in flight, no overlap).
- in_valid while busy is ignored. The source must hold A/B until in_ready is 1.
- rst asserted in any state aborts the operation: the state becomes IDLE and out_valid becomes 0 at that edge, and the in-flight result is discarded.
- out_ready is don't-care outside DONE.

## Configuration
- BFP16_DIV_RNE_EN defined: round-to-nearest-even. Increment mant when guard && (sticky || mant[0]).
- BFP16_DIV_RNE_EN undefined: truncate (guard and sticky ignored), matching the multiplier's truncation.
- Latency is identical in both builds.

## Structure
- Package bfp16_pkg holds:
  - typedef bfp16_t (packed struct: sign, exp[7:0], frac[6:0]);
  - BFP16_EXP_BIAS = 127;
  - BFP16_QNAN = 16'h7FC0;
  - BFP16_DIV_ITERS = 10;
  - FSM state enum.
- One sub-module, bfp16_classify: combinational per-operand is_nan / is_inf / is_zero (subnormals count as zero). Instantiated twice, for A and B.

## Test plan
- 0x3F80 / 0x4000 → O = 0x3F00. out_valid exactly 12 cycles after accept. 0x4040 / 0x3FC0 → 0x4000.
- 0x3F80 / 0x4040 (1/3) → 0x3EAA with macro off, 0x3EAB with BFP16_DIV_RNE_EN.
- Specials, each with out_valid 1 cycle after accept:
  - 0x0000 / 0x0000 → 0x7FC0;
  - 0xC000 / 0x0000 → 0xFF80;
  - 0x7F80 / 0x7F80 → 0x7FC0;
  - 0x3F80 / 0x7F80 → 0x0000;
  - 0x7FC1 / 0x3F80 → 0x7FC1.
- Range limits:
  - 0x7F00 / 0x0080 → 0x7F80 (overflow);
  - 0x0080 / 0x4000 → 0x0000 (flush);
  - 0x0001 / 0x3F80 → 0x0000 (subnormal input).
- Backpressure: out_ready held low 5 cycles in DONE → O and out_valid stable, in_ready = 0. Also, in_valid pulsed during DIV → ignored.
- rst pulsed at DIV cycle 4 → out_valid stays 0 and in_ready = 1 the cycle after rst drops. A following 0x4000 / 0x4000 → 0x3F80.
